// File: rtl/strobe_sequencer.sv
// strobe_sequencer: frame timer with camera trigger, plus an edge-divided, delayed, one-per-frame strobe pulse.
// Optional macro STROBE_SEQ_DEBOUNCE_EN adds a DEB_LEN-cycle stability filter on the synchronized ext_in.
module strobe_sequencer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 800000,
  parameter int unsigned MIN_PERIOD     = 48000,
  parameter int unsigned CAM_PULSE      = 480,
  parameter int unsigned DEB_LEN        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_valid,
  input  logic             ext_in,
  input  logic [7:0]       divisor,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic             enable,
  output logic             cam_trig,
  output logic             strobe,
  output logic             missed,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CAM_LAST = CNT_W'(CAM_PULSE - 1);
  localparam int unsigned      DEB_W    = $clog2(DEB_LEN + 1);
`ifdef STROBE_SEQ_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  state_t           st, st_n;
  logic [CNT_W-1:0] shadow, active, count;
  logic             frame_tick;
  logic             ext_s1, ext_s2, ext_lvl, lvl_d, edge_r;
  logic [DEB_W-1:0] deb_cnt;
  logic [7:0]       div_cnt, div_last;
  logic             div_edge;
  logic [CNT_W-1:0] cnt, cnt_n, pw_s, pw_s_n;
  logic             pending, pending_n, missed_n;

  assign state = st;

  // Frame timer: shadow period only moves into active at the wrap
  assign frame_tick = (count == active - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= DEF_P;
      active   <= DEF_P;
      count    <= '0;
      cam_trig <= 1'b0;
    end else begin
      if (period_valid)
        shadow <= (period_in < MIN_P) ? MIN_P : period_in;
      if (frame_tick) begin
        count    <= '0;
        active   <= shadow;
        cam_trig <= 1'b1;
      end else begin
        count    <= count + ONE;
        cam_trig <= cam_trig && (count < CAM_LAST);
      end
    end
  end

  // Debounce counter is always present; it only feeds the edge path when enabled
  assign ext_lvl  = DEB_EN ? (deb_cnt == DEB_W'(DEB_LEN)) : ext_s2;
  assign div_last = (divisor == 8'd0) ? 8'd0 : divisor - 8'd1;
  assign div_edge = (st == ARMED) && edge_r && (div_cnt == div_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_s1  <= 1'b0;
      ext_s2  <= 1'b0;
      lvl_d   <= 1'b0;
      edge_r  <= 1'b0;
      deb_cnt <= '0;
      div_cnt <= '0;
    end else begin
      ext_s1 <= ext_in;
      ext_s2 <= ext_s1;
      lvl_d  <= ext_lvl;
      edge_r <= ext_lvl & ~lvl_d;
      if (!ext_s2)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_W'(DEB_LEN))
        deb_cnt <= deb_cnt + DEB_W'(1);
      if (st != ARMED)
        div_cnt <= '0;
      else if (edge_r)
        div_cnt <= (div_cnt == div_last) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      cnt     <= '0;
      pw_s    <= ONE;
      pending <= 1'b0;
      strobe  <= 1'b0;
      missed  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      pw_s    <= pw_s_n;
      pending <= pending_n;
      strobe  <= enable && (st == PULSE);
      missed  <= missed_n;
    end
  end

  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    pw_s_n    = pw_s;
    pending_n = pending;
    missed_n  = 1'b0;
    if (!enable) begin
      st_n      = IDLE;
      pending_n = 1'b0;
    end else begin
      case (st)
        IDLE:
          if (frame_tick) st_n = ARMED;
        ARMED:
          if (div_edge) begin
            // An edge coinciding with the frame tick wins; the tick becomes pending
            pw_s_n    = (pulse_width == '0) ? ONE : pulse_width;
            pending_n = frame_tick;
            if (delay == '0) begin
              st_n  = PULSE;
              cnt_n = pw_s_n;
            end else begin
              st_n  = DELAY;
              cnt_n = delay;
            end
          end else if (frame_tick) begin
            missed_n = 1'b1;
          end
        DELAY: begin
          if (frame_tick) pending_n = 1'b1;
          if (cnt <= ONE) begin
            st_n  = PULSE;
            cnt_n = pw_s;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
        PULSE:
          if (cnt <= ONE) begin
            st_n      = (pending || frame_tick) ? ARMED : IDLE;
            pending_n = 1'b0;
          end else begin
            cnt_n = cnt - ONE;
            if (frame_tick) pending_n = 1'b1;
          end
        default:
          st_n = IDLE;
      endcase
    end
  end

endmodule
